// File: rtl/orion_pll_supervisor.sv
// PLL lock supervisor and downstream reset sequencer, clocked by the board reference clock.
// Build option ORION_PLL_SUP_AUTORETRY_EN enables automatic retries and re-arm on lock loss.
//
// state | meaning
// PRST  | PLL held in reset for RST_PULSE_CYC cycles
// WAIT  | waiting for LOCK_STABLE_CYC consecutive locked cycles, bounded by LOCK_TIMEOUT_CYC
// RUN   | lock stable, downstream reset released
// FAULT | retries exhausted, PLL held in reset until clear_fault
module orion_pll_supervisor #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int MAX_RETRIES      = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       clear_fault,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       pll_ok,
    output logic       fault,
    output logic [7:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam int CNT_MAX = (LOCK_TIMEOUT_CYC > RST_PULSE_CYC) ? LOCK_TIMEOUT_CYC : RST_PULSE_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int SW      = $clog2(LOCK_STABLE_CYC + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [SW-1:0] STB_LAST = SW'(LOCK_STABLE_CYC - 1);
`ifdef ORION_PLL_SUP_AUTORETRY_EN
    localparam logic [7:0]    RETRY_MAX = 8'(MAX_RETRIES);
`endif

    if (RST_PULSE_CYC < 1 || LOCK_STABLE_CYC < 1 || LOCK_TIMEOUT_CYC <= LOCK_STABLE_CYC ||
        MAX_RETRIES < 0 || MAX_RETRIES > 255) begin : g_param_check
        $error("orion_pll_supervisor: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_PRST  = 2'd0,
        S_WAIT  = 2'd1,
        S_RUN   = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          lk_meta_q, lk_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] stb_q, stb_d;
    logic [7:0]    retry_q, retry_d;
    logic [7:0]    loss_q, loss_d;
    logic          pll_rst_q, pll_rst_d;
    logic          sys_rst_n_q, sys_rst_n_d;
    logic          pll_ok_q, pll_ok_d;
    logic          fault_q, fault_d;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lk_meta_q <= 1'b0;
            lk_s_q    <= 1'b0;
        end else begin
            lk_meta_q <= pll_locked;
            lk_s_q    <= lk_meta_q;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_PRST;
            cnt_q       <= '0;
            stb_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            pll_ok_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stb_q       <= stb_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            pll_ok_q    <= pll_ok_d;
            fault_q     <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stb_d   = stb_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        case (state_q)
            S_PRST: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                stb_d = lk_s_q ? stb_q + SW'(1) : '0;
                // a stable lock completing on the timeout cycle still wins
                if (lk_s_q && (stb_q == STB_LAST)) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end else if (cnt_q == TMO_LAST) begin
`ifdef ORION_PLL_SUP_AUTORETRY_EN
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 8'd1;
                        state_d = S_PRST;
                    end else begin
                        state_d = S_FAULT;
                    end
`else
                    state_d = S_FAULT;
`endif
                end
            end
            S_RUN: begin
                if (!lk_s_q) begin
                    loss_d = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
`ifdef ORION_PLL_SUP_AUTORETRY_EN
                    state_d = S_PRST;
`else
                    state_d = S_FAULT;
`endif
                end
            end
            S_FAULT: begin
                if (clear_fault) begin
                    retry_d = '0;
                    state_d = S_PRST;
                end
            end
            default: begin
                state_d = S_PRST;
            end
        endcase

        // every state change starts the next phase with fresh counters
        if (state_d != state_q) begin
            cnt_d = '0;
            stb_d = '0;
        end

        pll_rst_d   = (state_d == S_PRST) || (state_d == S_FAULT);
        sys_rst_n_d = (state_d == S_RUN);
        pll_ok_d    = (state_d == S_RUN);
        fault_d     = (state_d == S_FAULT);
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign pll_ok    = pll_ok_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;

endmodule
